branch_redirect_unit: RTL and testbench

Consumer end of the jump/branch control strobes. It takes the decoded J/JW/JR/BEQ/BNE/BGEZ strobes for the instruction in EX, resolves the branch condition and target, and owns the fetch PC register. It issues a registered PC redirect, a link write for jal, and a flush window that squashes wrong-path instructions. It sits between the control decoder and the instruction-fetch stage.

---
 rtl/branch_redirect_unit.sv | 160 ++++++++++++++++
 tb/tb_branch_redirect_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_unit.sv
// Resolves EX-stage jump/branch strobes, owns the fetch PC and drives redirect, link and flush.
// Latency 1 (all outputs registered); in_stall freezes every register and drops the pulses.
module branch_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_valid,
  input  logic        in_J,
  input  logic        in_JW,
  input  logic        in_JR,
  input  logic        in_BEQ,
  input  logic        in_BNE,
  input  logic        in_BGEZ,
  input  logic [31:0] in_pc_ex,
  input  logic [15:0] in_imm16,
  input  logic [25:0] in_index26,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  input  logic        in_stall,
  input  logic        in_halt,
  output logic [31:0] out_pc,
  output logic        out_flush,
  output logic [31:0] out_link,
  output logic        out_link_we,
  output logic        out_misalign,
  output logic [31:0] out_taken_cnt,
  output logic        out_halted
);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, HALT = 2'd2} state_t;

  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic [31:0] link_q, link_d;
  logic        link_we_q, link_we_d;
  logic        misalign_q, misalign_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic        halted_q, halted_d;

  logic [31:0] link_val, br_tgt, j_tgt, jr_tgt, target;
  logic        cond, take;

  assign link_val = in_pc_ex + 32'd4;
  assign br_tgt   = link_val + {{14{in_imm16[15]}}, in_imm16, 2'b00};
  assign j_tgt    = {link_val[31:28], in_index26, 2'b00};
  assign jr_tgt   = {in_rs_val[31:2], 2'b00};

  // Priority JR > J > BEQ > BNE > BGEZ; only the winning strobe's condition counts.
  always_comb begin
    cond   = 1'b0;
    target = br_tgt;
    if (in_JR) begin
      cond   = 1'b1;
      target = jr_tgt;
    end else if (in_J) begin
      cond   = 1'b1;
      target = j_tgt;
    end else if (in_BEQ) begin
      cond = (in_rs_val == in_rt_val);
    end else if (in_BNE) begin
      cond = (in_rs_val != in_rt_val);
    end else if (in_BGEZ) begin
      cond = ~in_rs_val[31];
    end
  end

  assign take = in_valid & cond;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pc_d        = pc_q;
    flush_d     = flush_q;
    link_d      = link_q;
    link_we_d   = 1'b0;
    misalign_d  = 1'b0;
    taken_cnt_d = taken_cnt_q;
    halted_d    = halted_q;
    if (!in_stall) begin
      case (state_q)
        RUN: begin
          if (in_halt) begin
            state_d  = HALT;
            halted_d = 1'b1;
            flush_d  = 1'b0;
          end else if (take) begin
            pc_d        = target;
            flush_d     = 1'b1;
            fcnt_d      = FCNT_INIT;
            taken_cnt_d = taken_cnt_q + 32'd1;
            state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            if (in_JW && (in_JR || in_J)) begin
              link_we_d = 1'b1;
              link_d    = link_val;
            end
            misalign_d = in_JR && (in_rs_val[1:0] != 2'b00);
          end else begin
            pc_d    = pc_q + 32'd4;
            flush_d = 1'b0;
          end
        end
        FLUSH: begin
          if (in_halt) begin
            state_d  = HALT;
            halted_d = 1'b1;
            flush_d  = 1'b0;
          end else begin
            pc_d = pc_q + 32'd4;
            if (fcnt_q != 3'd0) begin
              fcnt_d = fcnt_q - 3'd1;
            end else begin
              flush_d = 1'b0;
              state_d = RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q     <= RUN;
      fcnt_q      <= 3'd0;
      pc_q        <= RESET_PC;
      flush_q     <= 1'b0;
      link_q      <= 32'd0;
      link_we_q   <= 1'b0;
      misalign_q  <= 1'b0;
      taken_cnt_q <= 32'd0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      link_q      <= link_d;
      link_we_q   <= link_we_d;
      misalign_q  <= misalign_d;
      taken_cnt_q <= taken_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign out_pc        = pc_q;
  assign out_flush     = flush_q;
  assign out_link      = link_q;
  assign out_link_we   = link_we_q;
  assign out_misalign  = misalign_q;
  assign out_taken_cnt = taken_cnt_q;
  assign out_halted    = halted_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: reset, branch/jump redirects, flush, stall, halt.
module tb_branch_redirect_unit;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_valid, in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ;
  logic [31:0] in_pc_ex;
  logic [15:0] in_imm16;
  logic [25:0] in_index26;
  logic [31:0] in_rs_val, in_rt_val;
  logic        in_stall, in_halt;
  logic [31:0] out_pc, out_link, out_taken_cnt;
  logic        out_flush, out_link_we, out_misalign, out_halted;

  int checks = 0;
  int errs   = 0;

  always #5 in_clk = ~in_clk;

  branch_redirect_unit #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid),
    .in_J(in_J), .in_JW(in_JW), .in_JR(in_JR),
    .in_BEQ(in_BEQ), .in_BNE(in_BNE), .in_BGEZ(in_BGEZ),
    .in_pc_ex(in_pc_ex), .in_imm16(in_imm16), .in_index26(in_index26),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_stall(in_stall), .in_halt(in_halt),
    .out_pc(out_pc), .out_flush(out_flush), .out_link(out_link),
    .out_link_we(out_link_we), .out_misalign(out_misalign),
    .out_taken_cnt(out_taken_cnt), .out_halted(out_halted)
  );

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic clear_strobes();
    in_valid = 0; in_J = 0; in_JW = 0; in_JR = 0;
    in_BEQ = 0; in_BNE = 0; in_BGEZ = 0;
  endtask

  task automatic test_reset();
    clear_strobes();
    in_pc_ex = 0; in_imm16 = 0; in_index26 = 0; in_rs_val = 0; in_rt_val = 0;
    in_stall = 0; in_halt = 0;
    in_rst = 1;
    #3;
    checks++; if (out_pc !== 32'h0) begin errs++; $display("FAIL reset_pc got %h exp %h", out_pc, 32'h0); end
    checks++; if (out_flush !== 1'b0) begin errs++; $display("FAIL reset_flush got %b exp 0", out_flush); end
    checks++; if (out_taken_cnt !== 32'h0) begin errs++; $display("FAIL reset_cnt got %0d exp 0", out_taken_cnt); end
    checks++; if (out_halted !== 1'b0 || out_link_we !== 1'b0 || out_misalign !== 1'b0 || out_link !== 32'h0)
      begin errs++; $display("FAIL reset_misc got halted=%b we=%b mis=%b link=%h exp 0", out_halted, out_link_we, out_misalign, out_link); end
    step();
    in_rst = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (out_pc !== 32'(4 * i)) begin errs++; $display("FAIL idle_pc%0d got %h exp %h", i, out_pc, 32'(4 * i)); end
      checks++; if (out_flush !== 1'b0) begin errs++; $display("FAIL idle_flush%0d got %b exp 0", i, out_flush); end
    end
  endtask

  task automatic test_beq_flush();
    in_valid = 1; in_BEQ = 1; in_rs_val = 5; in_rt_val = 5; in_pc_ex = 32'h100; in_imm16 = 16'hFFFE;
    step();
    checks++; if (out_pc !== 32'h0FC) begin errs++; $display("FAIL beq_pc got %h exp %h", out_pc, 32'h0FC); end
    checks++; if (out_flush !== 1'b1) begin errs++; $display("FAIL beq_flush0 got %b exp 1", out_flush); end
    checks++; if (out_taken_cnt !== 32'd1) begin errs++; $display("FAIL beq_cnt got %0d exp 1", out_taken_cnt); end
    // Taken-looking BNE on the wrong path must be ignored.
    in_BEQ = 0; in_BNE = 1; in_rs_val = 5; in_rt_val = 6; in_pc_ex = 32'h800; in_imm16 = 16'h0010;
    step();
    checks++; if (out_pc !== 32'h100) begin errs++; $display("FAIL flush_pc1 got %h exp %h", out_pc, 32'h100); end
    checks++; if (out_flush !== 1'b1) begin errs++; $display("FAIL beq_flush1 got %b exp 1", out_flush); end
    step();
    checks++; if (out_pc !== 32'h104) begin errs++; $display("FAIL flush_pc2 got %h exp %h", out_pc, 32'h104); end
    checks++; if (out_flush !== 1'b0) begin errs++; $display("FAIL beq_flush2 got %b exp 0", out_flush); end
    checks++; if (out_taken_cnt !== 32'd1) begin errs++; $display("FAIL flush_bne_cnt got %0d exp 1", out_taken_cnt); end
    clear_strobes();
    step();
    checks++; if (out_pc !== 32'h108) begin errs++; $display("FAIL post_flush_pc got %h exp %h", out_pc, 32'h108); end
  endtask

  task automatic test_jal();
    in_valid = 1; in_J = 1; in_JW = 1; in_pc_ex = 32'h4000_0010; in_index26 = 26'h40;
    step();
    checks++; if (out_pc !== 32'h4000_0100) begin errs++; $display("FAIL jal_pc got %h exp %h", out_pc, 32'h4000_0100); end
    checks++; if (out_link_we !== 1'b1) begin errs++; $display("FAIL jal_we got %b exp 1", out_link_we); end
    checks++; if (out_link !== 32'h4000_0014) begin errs++; $display("FAIL jal_link got %h exp %h", out_link, 32'h4000_0014); end
    checks++; if (out_taken_cnt !== 32'd2) begin errs++; $display("FAIL jal_cnt got %0d exp 2", out_taken_cnt); end
    clear_strobes();
    step();
    checks++; if (out_link_we !== 1'b0) begin errs++; $display("FAIL jal_we_drop got %b exp 0", out_link_we); end
    checks++; if (out_link !== 32'h4000_0014) begin errs++; $display("FAIL jal_link_hold got %h exp %h", out_link, 32'h4000_0014); end
    step();
  endtask

  task automatic test_jr_priority();
    in_valid = 1; in_JR = 1; in_BEQ = 1; in_rs_val = 32'h1003; in_rt_val = 32'h5; in_pc_ex = 32'h200; in_imm16 = 16'h0040;
    step();
    checks++; if (out_pc !== 32'h1000) begin errs++; $display("FAIL jr_pc got %h exp %h", out_pc, 32'h1000); end
    checks++; if (out_misalign !== 1'b1) begin errs++; $display("FAIL jr_misalign got %b exp 1", out_misalign); end
    checks++; if (out_link_we !== 1'b0) begin errs++; $display("FAIL jr_nolink got %b exp 0", out_link_we); end
    checks++; if (out_taken_cnt !== 32'd3) begin errs++; $display("FAIL jr_cnt got %0d exp 3", out_taken_cnt); end
    clear_strobes();
    step();
    checks++; if (out_misalign !== 1'b0) begin errs++; $display("FAIL jr_misalign_drop got %b exp 0", out_misalign); end
    step();
    checks++; if (out_pc !== 32'h1008) begin errs++; $display("FAIL jr_after_pc got %h exp %h", out_pc, 32'h1008); end
  endtask

  task automatic test_bgez_stall();
    in_valid = 1; in_BGEZ = 1; in_rs_val = 32'h8000_0000;
    step();
    checks++; if (out_pc !== 32'h100C) begin errs++; $display("FAIL bgez_pc got %h exp %h", out_pc, 32'h100C); end
    checks++; if (out_flush !== 1'b0) begin errs++; $display("FAIL bgez_flush got %b exp 0", out_flush); end
    in_BGEZ = 0; in_BNE = 1; in_rs_val = 1; in_rt_val = 2; in_pc_ex = 32'h300; in_imm16 = 16'h0004;
    in_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_pc !== 32'h100C || out_flush !== 1'b0) begin errs++; $display("FAIL stall_hold%0d got pc=%h flush=%b exp pc=%h flush=0", i, out_pc, out_flush, 32'h100C); end
    end
    checks++; if (out_taken_cnt !== 32'd3) begin errs++; $display("FAIL stall_cnt got %0d exp 3", out_taken_cnt); end
    in_stall = 0;
    step();
    checks++; if (out_pc !== 32'h314) begin errs++; $display("FAIL unstall_pc got %h exp %h", out_pc, 32'h314); end
    checks++; if (out_taken_cnt !== 32'd4) begin errs++; $display("FAIL unstall_cnt got %0d exp 4", out_taken_cnt); end
    clear_strobes();
    step();
    step();
    checks++; if (out_pc !== 32'h31C) begin errs++; $display("FAIL unstall_after_pc got %h exp %h", out_pc, 32'h31C); end
  endtask

  task automatic test_halt();
    in_valid = 1; in_J = 1; in_index26 = 26'h123; in_pc_ex = 32'h500; in_halt = 1;
    step();
    checks++; if (out_halted !== 1'b1) begin errs++; $display("FAIL halt_flag got %b exp 1", out_halted); end
    checks++; if (out_pc !== 32'h31C) begin errs++; $display("FAIL halt_pc got %h exp %h", out_pc, 32'h31C); end
    checks++; if (out_flush !== 1'b0 || out_taken_cnt !== 32'd4) begin errs++; $display("FAIL halt_noredirect got flush=%b cnt=%0d exp flush=0 cnt=4", out_flush, out_taken_cnt); end
    in_halt = 0;
    step();
    step();
    checks++; if (out_pc !== 32'h31C || out_halted !== 1'b1) begin errs++; $display("FAIL halt_stays got pc=%h halted=%b exp pc=%h halted=1", out_pc, out_halted, 32'h31C); end
    clear_strobes();
  endtask

  task automatic test_reset_mid_flush();
    in_rst = 1;
    #2;
    checks++; if (out_halted !== 1'b0 || out_pc !== 32'h0) begin errs++; $display("FAIL halt_reset got halted=%b pc=%h exp 0 0", out_halted, out_pc); end
    in_rst = 0;
    in_valid = 1; in_BEQ = 1; in_rs_val = 9; in_rt_val = 9; in_pc_ex = 32'h40; in_imm16 = 16'h0010;
    step();
    checks++; if (out_pc !== 32'h84 || out_flush !== 1'b1) begin errs++; $display("FAIL pre_reset_flush got pc=%h flush=%b exp pc=%h flush=1", out_pc, out_flush, 32'h84); end
    clear_strobes();
    #2;
    in_rst = 1;
    #1;
    checks++; if (out_pc !== 32'h0 || out_flush !== 1'b0 || out_taken_cnt !== 32'd0) begin errs++; $display("FAIL mid_flush_reset got pc=%h flush=%b cnt=%0d exp 0 0 0", out_pc, out_flush, out_taken_cnt); end
    in_rst = 0;
    step();
    checks++; if (out_pc !== 32'h4 || out_flush !== 1'b0) begin errs++; $display("FAIL after_reset got pc=%h flush=%b exp pc=4 flush=0", out_pc, out_flush); end
  endtask

  initial begin
    test_reset();
    test_beq_flush();
    test_jal();
    test_jr_priority();
    test_bgez_stall();
    test_halt();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
